// File: rtl/mult_ctrl_pkg.sv
// Shared types and widths for the sequential 16x16 multiplier.
// One 8x8 partial product is folded into the accumulator per MUL state.
package mult_ctrl_pkg;

  localparam int OP_W   = 16;
  localparam int PP_W   = 8;
  localparam int PROD_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    MUL0,
    MUL1,
    MUL2,
    MUL3,
    DONE
  } state_t;

  function automatic logic is_mul(state_t s);
    return (s == MUL0) || (s == MUL1) || (s == MUL2) || (s == MUL3);
  endfunction

  // Cross terms sit one byte up, the high*high term two bytes up.
  function automatic logic [4:0] pp_shift(state_t s);
    logic [4:0] sh;
    case (s)
      MUL1, MUL2: sh = 5'd8;
      MUL3:       sh = 5'd16;
      default:    sh = 5'd0;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/mult16_seq_ctrl_if.sv
// Operand/product handshake bundle for mult16_seq_ctrl.
// slave = multiplier side, master = the block feeding operands and taking products.
interface mult16_seq_ctrl_if;
  import mult_ctrl_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   a;
  logic [OP_W-1:0]   b;
  logic              out_valid;
  logic              out_ready;
  logic [PROD_W-1:0] product;
  logic              busy;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

endinterface

// File: rtl/mult16_seq_ctrl_pp_mult8.sv
// Combinational 8x8 -> 16 unsigned multiplier shared by all partial products.
// Zero latency, no state, no handshake.
module pp_mult8
  import mult_ctrl_pkg::*;
(
  input  logic [PP_W-1:0]   x,
  input  logic [PP_W-1:0]   y,
  output logic [2*PP_W-1:0] p
);

  assign p = {{PP_W{1'b0}}, x} * {{PP_W{1'b0}}, y};

endmodule

// File: rtl/mult16_seq_ctrl.sv
// Sequential 16x16 unsigned multiplier: product valid 5 edges after accept (2 when upper bytes are zero and SKIP_ZERO=1).
// One operation in flight; in_ready only in IDLE, DONE holds the product until out_ready.
module mult16_seq_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter bit SKIP_ZERO = 1'b1
)
(
  input  logic            clk,
  input  logic            reset_n,
  mult16_seq_ctrl_if.slave bus
);

  state_t            state_q;
  state_t            state_nxt;
  logic [OP_W-1:0]   a_q;
  logic [OP_W-1:0]   b_q;
  logic [PROD_W-1:0] acc_q;
  logic              out_valid_q;

  logic [PP_W-1:0]   pp_x;
  logic [PP_W-1:0]   pp_y;
  logic [2*PP_W-1:0] pp;
  logic [PROD_W-1:0] pp_aligned;

  logic in_hs;
  logic out_hs;
  logic hi_zero;

  assign in_hs   = bus.in_valid && (state_q == IDLE);
  assign out_hs  = out_valid_q && bus.out_ready;
  assign hi_zero = (a_q[OP_W-1:PP_W] == '0) && (b_q[OP_W-1:PP_W] == '0);

  always_comb begin
    pp_x = '0;
    pp_y = '0;
    case (state_q)
      MUL0: begin
        pp_x = a_q[PP_W-1:0];
        pp_y = b_q[PP_W-1:0];
      end
      MUL1: begin
        pp_x = a_q[OP_W-1:PP_W];
        pp_y = b_q[PP_W-1:0];
      end
      MUL2: begin
        pp_x = a_q[PP_W-1:0];
        pp_y = b_q[OP_W-1:PP_W];
      end
      MUL3: begin
        pp_x = a_q[OP_W-1:PP_W];
        pp_y = b_q[OP_W-1:PP_W];
      end
      default: ;
    endcase
  end

  pp_mult8 u_pp_mult8 (
    .x (pp_x),
    .y (pp_y),
    .p (pp)
  );

  assign pp_aligned = PROD_W'(pp) << pp_shift(state_q);

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: if (in_hs) state_nxt = MUL0;
      MUL0: state_nxt = (SKIP_ZERO && hi_zero) ? DONE : MUL1;
      MUL1: state_nxt = MUL2;
      MUL2: state_nxt = MUL3;
      MUL3: state_nxt = DONE;
      DONE: if (out_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      if (in_hs) begin
        a_q   <= bus.a;
        b_q   <= bus.b;
        acc_q <= '0;
      end else if (is_mul(state_q)) begin
        acc_q <= acc_q + pp_aligned;
      end
      // out_valid registers one cycle after the accumulator settles in DONE.
      if (out_hs)
        out_valid_q <= 1'b0;
      else if (state_q == DONE)
        out_valid_q <= 1'b1;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.product   = acc_q;

endmodule
